// File: rtl/i2c_target.sv
// I2C target with an auto-incrementing register pointer.
// SCL/SDA are synchronized and glitch-filtered before any bus decode.
module i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h42,
  parameter int         FILT     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda,
  output logic       sda_oe,
  output logic       busy,
  output logic [7:0] reg_addr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       reg_wr,
  output logic [7:0] reg_wdata
);

  localparam int CW = $clog2(FILT + 1);

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    WDATA,
    WACK,
    RDATA,
    RACK,
    WAIT_STOP
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [1:0]    scl_sy;
  logic [1:0]    sda_sy;
  logic [CW-1:0] scl_cnt;
  logic [CW-1:0] sda_cnt;
  logic          scl_f;
  logic          sda_f;
  logic          scl_q;
  logic          sda_q;

  logic [3:0] cnt;
  logic [7:0] shreg;
  logic       ack_q;
  logic       rw_q;
  logic [1:0] rd_p;
  logic       sda_oe_d;

  logic start;
  logic stop;
  logic ev;
  logic rise;
  logic fall;
  logic last;
  logic match;

  // A filtered level flips only after FILT consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sy  <= 2'b11;
      sda_sy  <= 2'b11;
      scl_cnt <= '0;
      sda_cnt <= '0;
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
    end else begin
      scl_sy <= {scl_sy[0], scl};
      sda_sy <= {sda_sy[0], sda};
      scl_q  <= scl_f;
      sda_q  <= sda_f;
      if (scl_sy[1] == scl_f) begin
        scl_cnt <= '0;
      end else if (scl_cnt == CW'(FILT - 1)) begin
        scl_f   <= scl_sy[1];
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + CW'(1);
      end
      if (sda_sy[1] == sda_f) begin
        sda_cnt <= '0;
      end else if (sda_cnt == CW'(FILT - 1)) begin
        sda_f   <= sda_sy[1];
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + CW'(1);
      end
    end
  end

  assign start = scl_f & scl_q & sda_q & ~sda_f;
  assign stop  = scl_f & scl_q & ~sda_q & sda_f;
  assign ev    = start | stop;
  assign rise  = scl_f & ~scl_q & ~ev;
  assign fall  = ~scl_f & scl_q & ~ev;
  assign last  = (cnt == 4'd8);
  assign match = (shreg[7:1] == DEV_ADDR);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ADDR;
    end else if (stop) begin
      state_d = IDLE;
    end else if (fall) begin
      unique case (state_q)
        ADDR:     if (last) state_d = match ? ADDR_ACK : WAIT_STOP;
        ADDR_ACK: state_d = rw_q ? RDATA : PTR;
        PTR:      if (ack_q) state_d = WDATA;
        WDATA:    if (last) state_d = WACK;
        WACK:     state_d = WDATA;
        RDATA:    if (last) state_d = RACK;
        RACK:     state_d = ack_q ? RDATA : WAIT_STOP;
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    sda_oe_d = 1'b0;
    if (!ev) begin
      unique case (state_q)
        ADDR_ACK: sda_oe_d = 1'b1;
        WACK:     sda_oe_d = 1'b1;
        PTR:      sda_oe_d = ack_q;
        RDATA:    sda_oe_d = ~shreg[7];
        default:  sda_oe_d = 1'b0;
      endcase
    end
  end

  // reg_rd is registered, so it always pairs with the updated reg_addr
  always_ff @(posedge clk) begin
    if (rst) begin
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      reg_addr  <= 8'h00;
      reg_rd    <= 1'b0;
      reg_wr    <= 1'b0;
      reg_wdata <= 8'h00;
      cnt       <= 4'd0;
      shreg     <= 8'h00;
      ack_q     <= 1'b0;
      rw_q      <= 1'b0;
      rd_p      <= 2'b00;
    end else begin
      reg_rd <= 1'b0;
      reg_wr <= 1'b0;
      sda_oe <= sda_oe_d;
      rd_p   <= {rd_p[0], reg_rd};
      if (rd_p[1]) shreg <= reg_rdata;
      if (ev) begin
        cnt   <= 4'd0;
        ack_q <= 1'b0;
        busy  <= 1'b0;
      end else if (rise) begin
        unique case (state_q)
          ADDR, PTR, WDATA: begin
            if (!last) begin
              shreg <= {shreg[6:0], sda_f};
              cnt   <= cnt + 4'd1;
            end
            if (state_q == WDATA && cnt == 4'd7) begin
              reg_wdata <= {shreg[6:0], sda_f};
              reg_wr    <= 1'b1;
            end
          end
          ADDR_ACK: reg_rd <= rw_q;
          RDATA:    cnt <= cnt + 4'd1;
          RACK: begin
            ack_q <= ~sda_f;
            if (!sda_f) begin
              reg_addr <= reg_addr + 8'd1;
              reg_rd   <= 1'b1;
            end
          end
          default: ;
        endcase
      end else if (fall) begin
        unique case (state_q)
          ADDR: begin
            if (last) begin
              cnt  <= 4'd0;
              rw_q <= shreg[0];
              busy <= match;
            end
          end
          ADDR_ACK: cnt <= 4'd0;
          PTR: begin
            if (ack_q) begin
              ack_q <= 1'b0;
              cnt   <= 4'd0;
            end else if (last) begin
              reg_addr <= shreg;
              ack_q    <= 1'b1;
            end
          end
          WDATA: if (last) cnt <= 4'd0;
          WACK:  reg_addr <= reg_addr + 8'd1;
          RDATA: begin
            if (last) cnt <= 4'd0;
            else      shreg <= {shreg[6:0], 1'b1};
          end
          RACK: begin
            ack_q <= 1'b0;
            cnt   <= 4'd0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C master plus a register-file model.
// Expected bytes and pointers come from transaction-level arithmetic.
module tb_i2c_target;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       msda = 1'b1;
  logic       sda;
  logic       sda_oe;
  logic       busy;
  logic [7:0] reg_addr;
  logic       reg_rd;
  logic [7:0] reg_rdata = 8'h00;
  logic       reg_wr;
  logic [7:0] reg_wdata;

  int total = 0;
  int bad = 0;

  logic [15:0] wq[$];
  int          rd_cnt = 0;
  int          oe_cnt = 0;
  logic        p0v = 1'b0;
  logic        p1v = 1'b0;
  logic [7:0]  p0a = 8'h00;
  logic [7:0]  p1a = 8'h00;

  assign sda = msda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target #(
    .DEV_ADDR(7'h42),
    .FILT(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .scl(scl),
    .sda(sda),
    .sda_oe(sda_oe),
    .busy(busy),
    .reg_addr(reg_addr),
    .reg_rd(reg_rd),
    .reg_rdata(reg_rdata),
    .reg_wr(reg_wr),
    .reg_wdata(reg_wdata)
  );

  // Register file: ~addr is valid only in the 2nd cycle after reg_rd
  always @(negedge clk) begin
    reg_rdata <= p1v ? ~p1a : 8'($urandom);
    p1v <= p0v;
    p1a <= p0a;
    p0v <= reg_rd;
    p0a <= reg_addr;
    if (reg_wr) wq.push_back({reg_addr, reg_wdata});
    if (reg_rd) rd_cnt <= rd_cnt + 1;
    if (sda_oe) oe_cnt <= oe_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic bus_start();
    msda = 1'b1;
    tick(Q);
    scl = 1'b1;
    tick(Q);
    msda = 1'b0;
    tick(Q);
    scl = 1'b0;
    tick(Q);
  endtask

  task automatic bus_stop();
    msda = 1'b0;
    tick(Q);
    scl = 1'b1;
    tick(Q);
    msda = 1'b1;
    tick(Q);
  endtask

  task automatic wbit(input logic b, input logic glitch);
    msda = b;
    tick(Q);
    scl = 1'b1;
    if (glitch) begin
      tick(Q - 1);
      scl = 1'b0;
      tick(2);
      scl = 1'b1;
      tick(Q - 1);
    end else begin
      tick(2 * Q);
    end
    scl = 1'b0;
    tick(Q);
  endtask

  task automatic rbit(output logic b);
    msda = 1'b1;
    tick(Q);
    scl = 1'b1;
    tick(Q);
    b = sda;
    tick(Q);
    scl = 1'b0;
    tick(Q);
  endtask

  task automatic wbyte(input logic [7:0] d, output logic nk);
    for (int i = 7; i >= 0; i--) wbit(d[i], 1'b0);
    rbit(nk);
  endtask

  task automatic rbyte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      d[i] = b;
    end
    wbit(~ack, 1'b0);
  endtask

  task automatic do_write(input logic [7:0] p, input int n,
                          input logic [7:0] dat [4], input string tag);
    logic nk;
    wq.delete();
    bus_start();
    wbyte(8'h84, nk);
    chk({tag, "_aack"}, nk, 0);
    chk({tag, "_busy"}, busy, 1);
    wbyte(p, nk);
    chk({tag, "_pack"}, nk, 0);
    for (int i = 0; i < n; i++) begin
      wbyte(dat[i], nk);
      chk({tag, "_dack"}, nk, 0);
    end
    bus_stop();
    tick(4);
    chk({tag, "_nwr"}, wq.size(), n);
    for (int i = 0; i < n && i < wq.size(); i++)
      chk({tag, "_wr"}, wq[i], {8'(p + 8'(i)), dat[i]});
    chk({tag, "_ptr"}, reg_addr, 8'(p + 8'(n)));
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic do_read(input logic [7:0] p, input int n,
                         input string tag);
    logic       nk;
    logic [7:0] d;
    logic [7:0] a;
    logic [7:0] e;
    int         rd0;
    wq.delete();
    bus_start();
    wbyte(8'h84, nk);
    chk({tag, "_aack"}, nk, 0);
    wbyte(p, nk);
    chk({tag, "_pack"}, nk, 0);
    rd0 = rd_cnt;
    bus_start();
    wbyte(8'h85, nk);
    chk({tag, "_rack"}, nk, 0);
    for (int i = 0; i < n; i++) begin
      rbyte(d, i != n - 1);
      a = p + 8'(i);
      e = ~a;
      chk({tag, "_data"}, d, e);
    end
    tick(2);
    chk({tag, "_rel"}, sda_oe, 0);
    chk({tag, "_ptr"}, reg_addr, 8'(p + 8'(n - 1)));
    bus_stop();
    tick(4);
    chk({tag, "_nrd"}, rd_cnt - rd0, n);
    chk({tag, "_nwr"}, wq.size(), 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    logic       nk;
    logic [7:0] p;
    logic [7:0] dat [4];
    int         n;
    int         oe0;
    int         rd0;

    tick(4);
    rst = 1'b0;
    tick(1);
    chk("rst_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", reg_addr, 0);
    chk("rst_wdata", reg_wdata, 0);
    chk("rst_rd", reg_rd, 0);
    chk("rst_wr", reg_wr, 0);
    tick(Q);

    dat = '{8'hAA, 8'h55, 8'h00, 8'h00};
    do_write(8'h10, 2, dat, "wr");
    do_read(8'hFE, 3, "rdwrap");

    oe0 = oe_cnt;
    rd0 = rd_cnt;
    wq.delete();
    bus_start();
    wbyte(8'h90, nk);
    chk("bad_aack", nk, 1);
    chk("bad_busy", busy, 0);
    wbyte(8'h00, nk);
    chk("bad_dack", nk, 1);
    bus_stop();
    tick(4);
    chk("bad_oe", oe_cnt - oe0, 0);
    chk("bad_rd", rd_cnt - rd0, 0);
    chk("bad_wr", wq.size(), 0);

    oe0 = oe_cnt;
    scl = 1'b0;
    tick(2);
    scl = 1'b1;
    tick(Q);
    msda = 1'b0;
    tick(2);
    msda = 1'b1;
    tick(Q);
    chk("gl_busy", busy, 0);
    scl = 1'b0;
    tick(Q);
    wbyte(8'h84, nk);
    chk("gl_nostart", nk, 1);
    bus_stop();
    chk("gl_oe", oe_cnt - oe0, 0);
    bus_start();
    wbit(1'b1, 1'b1);
    for (int i = 6; i >= 0; i--) wbit(p[0] & 1'b0 | (i == 2), 1'b0);
    rbit(nk);
    chk("gl_sclack", nk, 0);
    bus_stop();
    tick(4);

    bus_start();
    wbyte(8'h84, nk);
    wbyte(8'h80, nk);
    bus_start();
    wbyte(8'h85, nk);
    chk("mr_aack", nk, 0);
    tick(2);
    chk("mr_drive", sda_oe, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mr_release", sda_oe, 0);
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("mr_ptr", reg_addr, 0);
    chk("mr_busy", busy, 0);
    scl = 1'b1;
    tick(Q);
    dat = '{8'h3C, 8'hC3, 8'h00, 8'h00};
    do_write(8'h05, 2, dat, "mr_wr");

    wq.delete();
    bus_start();
    wbyte(8'h84, nk);
    wbyte(8'h20, nk);
    for (int i = 0; i < 4; i++) wbit(1'(i & 1), 1'b0);
    bus_stop();
    tick(4);
    chk("sw_nwr", wq.size(), 0);
    chk("sw_busy", busy, 0);
    chk("sw_ptr", reg_addr, 8'h20);

    for (int k = 0; k < 4; k++) begin
      p = 8'($urandom);
      if (k == 0) p = 8'hFD;
      n = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) dat[i] = 8'($urandom);
      do_write(p, n, dat, "rnd_wr");
      do_read(p, n, "rnd_rd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
